// File: rtl/csa_pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package csa_pipe_adder_pkg;

  localparam int CSA_DEFAULT_WIDTH = 16;

  // Guarded so a bad BLOCK reaches the divisibility check instead of dividing by zero.
  function automatic int csa_nstage(input int width, input int block);
    return (block < 1) ? 1 : width / block;
  endfunction

endpackage

// File: rtl/csa_pipe_adder_defs.svh
// Shared defaults and elaboration checks for the pipelined carry-select adder.
`ifndef CSA_PIPE_ADDER_DEFS_SVH
`define CSA_PIPE_ADDER_DEFS_SVH

`define CSA_DEFAULT_BLOCK 4

`define CSA_CHECK_PARAMS(W, B) \
  if ((B) < 1) begin : g_bad_block \
    $error("csa_pipe_adder: BLOCK must be at least 1"); \
  end else if (((W) % (B)) != 0) begin : g_bad_width \
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK"); \
  end

`endif

// File: rtl/csa_slice.sv
// One carry-select slice: sums for both carry hypotheses, picked by the incoming carry.
`include "csa_pipe_adder_defs.svh"

module csa_slice
  import csa_pipe_adder_pkg::*;
#(
  parameter int BLOCK = `CSA_DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a_s,
  input  logic [BLOCK-1:0] b_s,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out
);

  logic [BLOCK-1:0] s0;
  logic [BLOCK-1:0] s1;
  logic             c0_out;
  logic             c1_out;

  always_comb begin : ripple
    logic c0;
    logic c1;
    c0 = 1'b0;
    c1 = 1'b1;
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i] = a_s[i] ^ b_s[i] ^ c0;
      s1[i] = a_s[i] ^ b_s[i] ^ c1;
      c0    = (a_s[i] & b_s[i]) | (c0 & (a_s[i] ^ b_s[i]));
      c1    = (a_s[i] & b_s[i]) | (c1 & (a_s[i] ^ b_s[i]));
    end
    c0_out = c0;
    c1_out = c1;
  end

  assign s     = c_in ? s1 : s0;
  assign c_out = c_in ? c1_out : c0_out;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder: one BLOCK-bit slice resolved per stage, valid/ready flow control.
`include "csa_pipe_adder_defs.svh"

module csa_pipe_adder
  import csa_pipe_adder_pkg::*;
#(
  parameter int WIDTH = CSA_DEFAULT_WIDTH,
  parameter int BLOCK = `CSA_DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = csa_nstage(WIDTH, BLOCK);

  `CSA_CHECK_PARAMS(WIDTH, BLOCK)

  logic adv;

  // Stage registers; operands travel whole so each stage picks its own slice.
  logic             valid_reg [NSTAGE];
  logic             carry_reg [NSTAGE];
  logic [WIDTH-1:0] a_reg     [NSTAGE];
  logic [WIDTH-1:0] b_reg     [NSTAGE];
  logic [WIDTH-1:0] sum_reg   [NSTAGE];
  logic             ovf_reg;

  // Inputs seen by each stage's combinational slice.
  logic             v_stage   [NSTAGE];
  logic             c_stage   [NSTAGE];
  logic [WIDTH-1:0] a_stage   [NSTAGE];
  logic [WIDTH-1:0] b_stage   [NSTAGE];
  logic [WIDTH-1:0] sum_stage [NSTAGE];
  logic [BLOCK-1:0] s_slice   [NSTAGE];
  logic             c_slice   [NSTAGE];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      logic [WIDTH-1:0] sum_next;

      if (gi == 0) begin : g_first
        assign v_stage[gi]   = in_valid;
        assign c_stage[gi]   = cin;
        assign a_stage[gi]   = a;
        assign b_stage[gi]   = b;
        assign sum_stage[gi] = '0;
      end else begin : g_next
        assign v_stage[gi]   = valid_reg[gi-1];
        assign c_stage[gi]   = carry_reg[gi-1];
        assign a_stage[gi]   = a_reg[gi-1];
        assign b_stage[gi]   = b_reg[gi-1];
        assign sum_stage[gi] = sum_reg[gi-1];
      end

      csa_slice #(
        .BLOCK (BLOCK)
      ) u_slice (
        .a_s   (a_stage[gi][gi*BLOCK +: BLOCK]),
        .b_s   (b_stage[gi][gi*BLOCK +: BLOCK]),
        .c_in  (c_stage[gi]),
        .s     (s_slice[gi]),
        .c_out (c_slice[gi])
      );

      // Lower result slices already resolved ride along; this stage fills in its own.
      always_comb begin
        sum_next                    = sum_stage[gi];
        sum_next[gi*BLOCK +: BLOCK] = s_slice[gi];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          carry_reg[gi] <= 1'b0;
          a_reg[gi]     <= '0;
          b_reg[gi]     <= '0;
          sum_reg[gi]   <= '0;
        end else if (adv) begin
          valid_reg[gi] <= v_stage[gi];
          carry_reg[gi] <= c_slice[gi];
          a_reg[gi]     <= a_stage[gi];
          b_reg[gi]     <= b_stage[gi];
          sum_reg[gi]   <= sum_next;
        end
      end
    end
  endgenerate

  // Overflow only needs the MSB slice, so it is formed in the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (adv) begin
      ovf_reg <= (a_stage[NSTAGE-1][WIDTH-1] == b_stage[NSTAGE-1][WIDTH-1]) &&
                 (s_slice[NSTAGE-1][BLOCK-1] != a_stage[NSTAGE-1][WIDTH-1]);
    end
  end

  assign out_valid = valid_reg[NSTAGE-1];
  assign sum       = sum_reg[NSTAGE-1];
  assign cout      = carry_reg[NSTAGE-1];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder (WIDTH=16, BLOCK=4): table vectors, directed sequences, random traffic.
module tb_csa_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          sent = 0;
  bit          accepted;
  logic [15:0] last_sum;
  logic        last_cout;
  logic        last_ovf;

  csa_pipe_adder #(
    .WIDTH (16),
    .BLOCK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned addition for sum/cout, signed range test for overflow.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input int mcyc);
    exp_t        e;
    logic [16:0] full;
    int          s;
    full   = {1'b0, ma} + {1'b0, mb} + {16'h0000, mc};
    s      = int'($signed(ma)) + int'($signed(mb)) + (mc ? 1 : 0);
    e.a    = ma;
    e.b    = mb;
    e.cin  = mc;
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (s > 32767) || (s < -32768);
    e.cyc  = mcyc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, then judge this cycle's transfers before the next rising edge.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic ordy, input bit lat);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    cyc++;
    accepted = 1'b0;
    if (out_valid) begin
      chk("beat_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q[0];
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        if (out_ready) begin
          if (lat) chk("latency", 32'(cyc - e.cyc), 32'd4);
          last_sum  = sum;
          last_cout = cout;
          last_ovf  = ovf;
          $display("out: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.cin, sum, cout, ovf);
          void'(q.pop_front());
        end else begin
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(a, b, cin, cyc));
      accepted = 1'b1;
      sent++;
    end
  endtask

  task automatic drain(input int max, input bit lat);
    int n;
    n = 0;
    while (q.size() > 0 && n < max) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, lat);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t tbl[8];
    int   i;
    int   guard;

    tbl[0] = '{16'h000F, 16'h0014, 1'b0, 16'h0023, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    do_reset();

    // Single isolated beats against hand-computed results.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, tbl[k].a, tbl[k].b, tbl[k].cin, 1'b1, 1'b1);
      chk("tbl_accept", 32'(accepted), 32'd1);
      drain(20, 1'b1);
      chk("tbl_sum", 32'(last_sum), 32'(tbl[k].esum));
      chk("tbl_cout", 32'(last_cout), 32'(tbl[k].ecout));
      chk("tbl_ovf", 32'(last_ovf), 32'(tbl[k].eovf));
    end

    // Back-to-back stream: every result exactly 4 cycles after its input.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 16'(k * 16'h1111), 16'h0101, k[0], 1'b1, 1'b1);
      chk("stream_accept", 32'(accepted), 32'd1);
    end
    drain(20, 1'b1);

    // Backpressure for 3 cycles mid-stream.
    i = 0;
    for (int c = 0; c < 40 && i < 8; c++) begin
      step(1'b1, 16'(i * 16'h0F0F + 16'h00F1), 16'(16'hF00F - i), i[1],
           !(c >= 5 && c < 8), 1'b0);
      if (accepted) i++;
    end
    chk("stall_all_sent", 32'(i), 32'd8);
    drain(30, 1'b0);

    // Reset with beats in flight; they must vanish, a fresh beat must survive.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'(16'h0101 * (k + 1)), 16'h00FF, 1'b1, 1'b1, 1'b1);
    end
    do_reset();
    step(1'b1, 16'h1234, 16'h0FFF, 1'b1, 1'b1, 1'b1);
    drain(20, 1'b1);
    chk("post_rst_sum", 32'(last_sum), 32'h2234);
    repeat (6) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    sent  = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom % 2),
           ($urandom % 4) != 0, 1'b0);
      guard++;
    end
    chk("random_sent", 32'(sent), 32'd10000);
    drain(50, 1'b0);
    repeat (6) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
